// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter driving single S/R pulses into a shared flag bank
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NFLAG-1:0]     s_vec,
  output logic [NFLAG-1:0]     r_vec,
  output logic [NFLAG-1:0]     flags,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 conflict,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // NFLAG may equal 2**IDXW, so compare with one extra bit of headroom.
  localparam logic [IDXW:0] NFLAG_W = (IDXW+1)'(NFLAG);

  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     win_q;
  logic [PW-1:0]     win_d;
  logic              op_q;
  logic              sel_op_d;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   sel_idx_d;
  logic [NFLAG-1:0]  s_q;
  logic [NFLAG-1:0]  r_q;
  logic [NFLAG-1:0]  flags_q;
  logic [NFLAG-1:0]  hit_d;
  logic [NREQ-1:0]   ack_q;
  logic              err_q;
  logic              conflict_q;
  logic              conflict_d;
  logic              busy_q;
  logic              in_range_d;
  logic              found_d;
  int                cand_d;

  assign s_vec    = s_q;
  assign r_vec    = r_q;
  assign flags    = flags_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign conflict = conflict_q;
  assign busy     = busy_q;

  // Round-robin pick: first pending requester scanning upward from ptr with wrap.
  always_comb begin
    win_d   = ptr_q;
    found_d = 1'b0;
    cand_d  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_d = int'(ptr_q) + k;
      if (cand_d >= NREQ) cand_d = cand_d - NREQ;
      if (!found_d && req[cand_d]) begin
        win_d   = PW'(cand_d);
        found_d = 1'b1;
      end
    end
  end

  // Mux out the winner's op and index with constant selects only.
  always_comb begin
    sel_op_d  = 1'b0;
    sel_idx_d = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (PW'(r) == win_d) begin
        sel_op_d  = op[r];
        sel_idx_d = idx[r*IDXW +: IDXW];
      end
    end
  end

  // Flag two pending requests that would set and clear the same valid flag.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (req[i] && req[j] && (op[i] != op[j]) &&
            (idx[i*IDXW +: IDXW] == idx[j*IDXW +: IDXW]) &&
            ({1'b0, idx[i*IDXW +: IDXW]} < NFLAG_W)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // One-hot decode of the latched index; an out-of-range index decodes to zero.
  always_comb begin
    hit_d      = '0;
    in_range_d = ({1'b0, idx_q} < NFLAG_W);
    for (int f = 0; f < NFLAG; f++) begin
      hit_d[f] = (idx_q == IDXW'(f));
    end
  end

  // Arbitration FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      op_q       <= 1'b0;
      idx_q      <= '0;
      s_q        <= '0;
      r_q        <= '0;
      flags_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s_q        <= '0;
      r_q        <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
      case (state_q)
        IDLE: begin
          conflict_q <= conflict_d;
          if (|req) begin
            win_q   <= win_d;
            op_q    <= sel_op_d;
            idx_q   <= sel_idx_d;
            state_q <= DRIVE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        DRIVE: begin
          if (op_q) begin
            s_q     <= hit_d;
            flags_q <= flags_q | hit_d;
          end else begin
            r_q     <= hit_d;
            flags_q <= flags_q & ~hit_d;
          end
          state_q <= ACK;
          busy_q  <= 1'b1;
        end
        ACK: begin
          for (int r = 0; r < NREQ; r++) begin
            ack_q[r] <= (PW'(r) == win_q);
          end
          err_q   <= ~in_range_d;
          ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
